// File: rtl/lm_sm_sequencer_if.sv
// lm_sm_sequencer_if
// Bundles the ID-side request (start/is_lm/reg_list), the pipeline controls
// (hold/flush) and the micro-op stream toward ID/EX.
//   master : ID stage / pipeline control, drives the request and controls
//   slave  : the LM/SM sequencer, drives busy/front_stall/uop_*/done
interface lm_sm_sequencer_if #(
  parameter int LIST_W = 8,
  parameter int DATA_W = 16
);
  localparam int RD_W = $clog2(LIST_W);

  logic              start;
  logic              is_lm;
  logic [LIST_W-1:0] reg_list;
  logic              hold;
  logic              flush;

  logic              busy;
  logic              front_stall;
  logic              uop_valid;
  logic              uop_lm;
  logic              uop_sm;
  logic [RD_W-1:0]   uop_rd;
  logic [DATA_W-1:0] uop_offset;
  logic              uop_last;
  logic              done;

  modport master (
    output start, is_lm, reg_list, hold, flush,
    input  busy, front_stall, uop_valid, uop_lm, uop_sm,
           uop_rd, uop_offset, uop_last, done
  );

  modport slave (
    input  start, is_lm, reg_list, hold, flush,
    output busy, front_stall, uop_valid, uop_lm, uop_sm,
           uop_rd, uop_offset, uop_last, done
  );
endinterface

// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer
// Expands one decoded LM/SM and its register list into a stream of
// single-register micro-ops (lowest register first), one per cycle, each with
// its Rd and base-relative word offset. Stalls the front end while in flight.
// Ports:
//   clock : pipeline clock, rising edge
//   clear : synchronous active-high reset
//   bus   : lm_sm_sequencer_if.slave (request, hold/flush, micro-op outputs)
//
// state | meaning
// IDLE  | no sequence; all uop_* outputs low
// ISSUE | presenting the micro-op for the lowest set bit of list_q
module lm_sm_sequencer #(
  parameter int LIST_W    = 8,
  parameter int DATA_W    = 16,
  parameter int ADDR_STEP = 1
) (
  input  logic clock,
  input  logic clear,
  lm_sm_sequencer_if.slave bus
);
  localparam int RD_W = $clog2(LIST_W);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state;
  logic [LIST_W-1:0] list_q;
  logic [DATA_W-1:0] offset_q;
  logic              lm_q;
  logic              done_q;

  logic [RD_W-1:0]   low_idx;
  logic [LIST_W-1:0] list_rest;
  logic              last_uop;
  logic              issuing;

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    low_idx = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (list_q[i]) low_idx = RD_W'(i);
    end
  end

  // x & (x-1) drops the lowest set bit; an empty remainder means one bit left.
  assign list_rest = list_q & (list_q - LIST_W'(1));
  assign last_uop  = (list_q != '0) && (list_rest == '0);
  assign issuing   = (state == ISSUE);

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      list_q   <= '0;
      offset_q <= '0;
      lm_q     <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.flush) begin
      state  <= IDLE;
      list_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && (bus.reg_list != '0)) begin
            state    <= ISSUE;
            list_q   <= bus.reg_list;
            lm_q     <= bus.is_lm;
            offset_q <= '0;
          end
        end
        ISSUE: begin
          if (!bus.hold) begin
            list_q   <= list_rest;
            offset_q <= offset_q + DATA_W'(ADDR_STEP);
            if (last_uop) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = issuing;
  // Release the front end in the cycle the final micro-op is accepted so the
  // next instruction enters ID exactly as the sequence retires.
  assign bus.front_stall = issuing & ~(last_uop & ~bus.hold);
  assign bus.uop_valid   = issuing;
  assign bus.uop_lm      = issuing & lm_q;
  assign bus.uop_sm      = issuing & ~lm_q;
  assign bus.uop_rd      = issuing ? low_idx : '0;
  assign bus.uop_offset  = issuing ? offset_q : '0;
  assign bus.uop_last    = issuing & last_uop;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_lm_sm_sequencer.sv
module tb_lm_sm_sequencer;
  typedef logic [25:0] vec_t;

  logic clock;
  logic clear;
  int   n_checks = 0;
  int   n_fail   = 0;

  lm_sm_sequencer_if bus ();

  lm_sm_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observed output vector: busy, front_stall, valid, lm, sm, rd, offset, last, done
  function automatic vec_t snap();
    return {bus.busy, bus.front_stall, bus.uop_valid, bus.uop_lm, bus.uop_sm,
            bus.uop_rd, bus.uop_offset, bus.uop_last, bus.done};
  endfunction

  function automatic vec_t ev_idle(bit dn);
    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, dn};
  endfunction

  function automatic vec_t ev_uop(bit lm, int rd, int off, bit last, bit h);
    return {1'b1, !(last && !h), 1'b1, lm, !lm, 3'(rd), 16'(off), last, 1'b0};
  endfunction

  task automatic set_in(bit s, bit lm, logic [7:0] list, bit h, bit f);
    bus.start    = s;
    bus.is_lm    = lm;
    bus.reg_list = list;
    bus.hold     = h;
    bus.flush    = f;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    vec_t e;
    clear = 1'b1;
    set_in(1, 1, 8'hFF, 0, 0);
    tick(); tick();
    clear = 1'b0;
    set_in(0, 0, 8'h00, 0, 0);
    #1;
    e = ev_idle(0);
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL reset: got %h expected %h", snap(), e);
    end
    tick();
  endtask

  task automatic test_lm_basic();
    int   rds [4] = '{0, 2, 5, 7};
    vec_t e;
    set_in(1, 1, 8'hA5, 0, 0);
    #1;
    e = ev_idle(0);
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL lm_start_cycle: got %h expected %h", snap(), e);
    end
    tick();
    set_in(0, 0, 8'h00, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      e = ev_uop(1, rds[k], k, k == 3, 0);
      n_checks++;
      if (snap() !== e) begin
        n_fail++; $display("FAIL lm_uop%0d: got %h expected %h", k, snap(), e);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      e = ev_idle(k == 0);
      n_checks++;
      if (snap() !== e) begin
        n_fail++; $display("FAIL lm_done%0d: got %h expected %h", k, snap(), e);
      end
      tick();
    end
  endtask

  task automatic test_sm_hold();
    int   rds [10] = '{0, 1, 2, 3, 3, 3, 4, 5, 6, 7};
    bit   hs  [10] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    vec_t e;
    set_in(1, 0, 8'hFF, 0, 0);
    tick();
    for (int k = 0; k < 10; k++) begin
      set_in(0, 0, 8'h00, hs[k], 0);
      #1;
      e = ev_uop(0, rds[k], rds[k], k == 9, hs[k]);
      n_checks++;
      if (snap() !== e) begin
        n_fail++; $display("FAIL sm_hold_cyc%0d: got %h expected %h", k, snap(), e);
      end
      tick();
    end
    #1;
    e = ev_idle(1);
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL sm_hold_done: got %h expected %h", snap(), e);
    end
    tick();
  endtask

  task automatic test_nop();
    vec_t e;
    set_in(1, 1, 8'h00, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      e = ev_idle(0);
      n_checks++;
      if (snap() !== e) begin
        n_fail++; $display("FAIL nop_cyc%0d: got %h expected %h", k, snap(), e);
      end
      tick();
      set_in(0, 0, 8'h00, 0, 0);
    end
  endtask

  task automatic test_flush();
    vec_t e;
    set_in(1, 1, 8'h18, 0, 0);
    tick();
    set_in(0, 0, 8'h00, 0, 1);
    #1;
    e = ev_uop(1, 3, 0, 0, 0);
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL flush_rd3: got %h expected %h", snap(), e);
    end
    tick();
    set_in(0, 0, 8'h00, 0, 0);
    for (int k = 0; k < 2; k++) begin
      #1;
      e = ev_idle(0);
      n_checks++;
      if (snap() !== e) begin
        n_fail++; $display("FAIL flush_after%0d: got %h expected %h", k, snap(), e);
      end
      tick();
    end
  endtask

  task automatic test_clear();
    vec_t e;
    set_in(1, 0, 8'hF0, 0, 0);
    tick();
    set_in(0, 0, 8'h00, 0, 0);
    #1;
    e = ev_uop(0, 4, 0, 0, 0);
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL clear_pre: got %h expected %h", snap(), e);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    e = ev_idle(0);
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL clear_idle: got %h expected %h", snap(), e);
    end
    set_in(1, 1, 8'h80, 0, 0);
    tick();
    set_in(0, 0, 8'h00, 0, 0);
    #1;
    e = ev_uop(1, 7, 0, 1, 0);
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL clear_restart: got %h expected %h", snap(), e);
    end
    tick();
    #1;
    e = ev_idle(1);
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL clear_restart_done: got %h expected %h", snap(), e);
    end
    tick();
  endtask

  task automatic test_single();
    vec_t e;
    set_in(1, 1, 8'h01, 0, 0);
    #1;
    n_checks++;
    if (bus.front_stall !== 1'b0) begin
      n_fail++; $display("FAIL single_start_stall: got %b expected 0", bus.front_stall);
    end
    tick();
    set_in(0, 0, 8'h00, 0, 0);
    #1;
    e = ev_uop(1, 0, 0, 1, 0);
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL single_uop: got %h expected %h", snap(), e);
    end
    tick();
    #1;
    e = ev_idle(1);
    n_checks++;
    if (snap() !== e) begin
      n_fail++; $display("FAIL single_done: got %h expected %h", snap(), e);
    end
    tick();
  endtask

  // Reference: a sequence is a queue of register numbers taken in ascending
  // order from the list; each accepted micro-op pops one and bumps the count.
  task automatic test_random();
    int         mq[$];
    bit         m_act  = 0;
    bit         m_lm   = 0;
    bit         m_done = 0;
    int         m_off  = 0;
    bit         s, lm, h, f, c;
    logic [7:0] list;
    vec_t       e;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      s    = ($urandom_range(0, 3) == 0);
      lm   = $urandom_range(0, 1);
      list = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      h    = ($urandom_range(0, 3) == 0);
      f    = ($urandom_range(0, 29) == 0);
      c    = ($urandom_range(0, 59) == 0);
      set_in(s, lm, list, h, f);
      clear = c;
      #1;
      e = m_act ? ev_uop(m_lm, mq[0], m_off, mq.size() == 1, h) : ev_idle(m_done);
      n_checks++;
      if (snap() !== e) begin
        n_fail++; $display("FAIL random_cyc%0d: got %h expected %h", cyc, snap(), e);
      end
      tick();
      if (c || f) begin
        m_act = 0; m_done = 0; mq.delete();
      end else begin
        m_done = 0;
        if (m_act) begin
          if (!h) begin
            void'(mq.pop_front());
            m_off = m_off + 1;
            if (mq.size() == 0) begin
              m_act = 0; m_done = 1;
            end
          end
        end else if (s && list != 8'h00) begin
          for (int i = 0; i < 8; i++) if (list[i]) mq.push_back(i);
          m_act = 1; m_lm = lm; m_off = 0;
        end
      end
    end
    clear = 1'b0;
    set_in(0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    clear = 1'b0;
    set_in(0, 0, 8'h00, 0, 0);
    test_reset();
    test_lm_basic();
    test_sm_hold();
    test_nop();
    test_flush();
    test_clear();
    test_single();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
